// File: rtl/shift_rows_pkg.sv
// rtl/shift_rows_pkg.sv - shared byte width, row helper and default block types for shift_rows_stream
package shift_rows_pkg;

    localparam int BYTE_W       = 8;
    localparam int DEF_REG_SIZE = 32;
    localparam int DEF_VEC_SIZE = 4;
    localparam int DEF_TAG_W    = 4;

    function automatic int rows_of(input int reg_size);
        return reg_size / BYTE_W;
    endfunction

    typedef logic [DEF_VEC_SIZE-1:0][DEF_REG_SIZE-1:0] vec_t;

    typedef struct packed {
        vec_t                 data;
        logic [DEF_TAG_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational ShiftRows byte permutation; SHIFT_ROWS_INV_EN adds InvShiftRows
module shift_rows_perm
    import shift_rows_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4
) (
    input  logic [vecSize-1:0][regSize-1:0] vect_in,
    input  logic                            inv,
    output logic [vecSize-1:0][regSize-1:0] vect_out
);

    localparam int ROWS = rows_of(regSize);

    // Byte r of a word sits at the MSB end; row r rotates by r columns.
    for (genvar c = 0; c < vecSize; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int HI = regSize - 1 - BYTE_W * r;
            localparam int SF = (c + r) % vecSize;
            localparam int SI = (c + vecSize - (r % vecSize)) % vecSize;
`ifdef SHIFT_ROWS_INV_EN
            assign vect_out[c][HI -: BYTE_W] = inv ? vect_in[SI][HI -: BYTE_W]
                                                   : vect_in[SF][HI -: BYTE_W];
`else
            assign vect_out[c][HI -: BYTE_W] = vect_in[SF][HI -: BYTE_W];
`endif
        end
    end

`ifndef SHIFT_ROWS_INV_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

endmodule

// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - streaming ShiftRows with 2-entry elastic output buffer; macro SHIFT_ROWS_INV_EN
module shift_rows_stream
    import shift_rows_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_inv,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic [vecSize-1:0][regSize-1:0] vect_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [TAG_W-1:0]                out_tag,
    output logic [vecSize-1:0][regSize-1:0] vect_out,
    output logic [CNT_W-1:0]                blk_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef struct packed {
        logic [vecSize-1:0][regSize-1:0] data;
        logic [TAG_W-1:0]                tag;
    } fifo_entry_t;

    logic [vecSize-1:0][regSize-1:0] perm_out;
    fifo_entry_t                     mem [2];
    logic [1:0]                      count;
    logic                            wr_ptr;
    logic                            rd_ptr;
    logic                            accept;
    logic                            pop;

    shift_rows_perm #(
        .regSize (regSize),
        .vecSize (vecSize)
    ) u_perm (
        .vect_in  (vect_in),
        .inv      (in_inv),
        .vect_out (perm_out)
    );

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    // A beat arriving alongside clear or rst is dropped and not counted.
    assign accept    = in_valid && in_ready && !clear && !rst;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            blk_count <= '0;
        end else if (clear) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr    <= ~wr_ptr;
                blk_count <= blk_count + CNT_ONE;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; empty-state outputs are forced to zero below.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= '{data: perm_out, tag: in_tag};
        end
    end

    always_comb begin
        vect_out = '0;
        out_tag  = '0;
        if (out_valid) begin
            vect_out = mem[rd_ptr].data;
            out_tag  = mem[rd_ptr].tag;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb/tb_shift_rows_stream.sv - directed self-checking bench for shift_rows_stream
module tb_shift_rows_stream;
    import shift_rows_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic        in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [3:0]  in_tag, out_tag;
    vec_t        vect_in, vect_out;
    logic [15:0] blk_count;

    logic                 in_valid2, in_ready2, out_valid2;
    logic [3:0]           out_tag2;
    logic [1:0][31:0]     vect_in2, vect_out2;
    logic [1:0]           blk_count2;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    shift_rows_stream u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_tag(in_tag),
        .vect_in(vect_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .vect_out(vect_out), .blk_count(blk_count)
    );

    shift_rows_stream #(.regSize(32), .vecSize(2), .TAG_W(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .clear(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_inv(1'b0), .in_tag(4'h0),
        .vect_in(vect_in2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_tag(out_tag2), .vect_out(vect_out2), .blk_count(blk_count2)
    );

    function automatic vec_t mk4(input logic [31:0] c0, c1, c2, c3);
        vec_t v;
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t v_plain, v_fwd, v_fwd2;

    initial begin
        v_plain = mk4(32'h7b5b5465, 32'h73745665, 32'h63746f72, 32'h5d53475d);
        v_fwd   = mk4(32'h7b746f5d, 32'h73744765, 32'h63535465, 32'h5d5b5672);
        v_fwd2  = mk4(32'h7b745472, 32'h7353565d, 32'h635b6f65, 32'h5d744765);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_tag = 4'h0;
        vect_in = '0; out_ready = 1'b0; in_valid2 = 1'b0; vect_in2 = '0;
        tick(); tick();
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready",  128'(in_ready),  128'(1'b1));
        check("rst_vect_out",  128'(vect_out),  128'h0);
        check("rst_out_tag",   128'(out_tag),   128'h0);
        check("rst_blk_count", 128'(blk_count), 128'h0);
        rst = 1'b0;
        exp_cnt = 16'd0;

        // Forward ShiftRows plus vecSize=2 generalisation on the second instance
        in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'd3; vect_in = v_plain;
        in_valid2 = 1'b1; vect_in2[0] = 32'h00112233; vect_in2[1] = 32'h44556677;
        tick();
        in_valid = 1'b0; exp_cnt++;
        check("fwd_out_valid", 128'(out_valid), 128'(1'b1));
        check("fwd_vect_out",  128'(vect_out),  128'(v_fwd));
        check("fwd_out_tag",   128'(out_tag),   128'h3);
        check("fwd_blk_count", 128'(blk_count), 128'(exp_cnt));
        check("gen_out_valid", 128'(out_valid2), 128'(1'b1));
        check("gen_vect_out0", 128'(vect_out2[0]), 128'h00552277);
        check("gen_vect_out1", 128'(vect_out2[1]), 128'h44116633);
        check("gen_blk_count", 128'(blk_count2), 128'h1);
        tick(); tick(); tick();
        in_valid2 = 1'b0;
        check("gen_cnt_wrap", 128'(blk_count2), 128'h0);
        check("hold_vect_out", 128'(vect_out), 128'(v_fwd));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fwd_drained", 128'(out_valid), 128'(1'b0));

        // Inverse beat; without the macro in_inv is ignored and the forward result appears
        in_valid = 1'b1; in_inv = 1'b1; in_tag = 4'd5; vect_in = v_fwd;
        tick();
        in_valid = 1'b0; in_inv = 1'b0; exp_cnt++;
`ifdef SHIFT_ROWS_INV_EN
        check("inv_vect_out", 128'(vect_out), 128'(v_plain));
`else
        check("inv_ignored_vect_out", 128'(vect_out), 128'(v_fwd2));
`endif
        check("inv_out_tag", 128'(out_tag), 128'h5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: two accepts fill the buffer, third beat waits
        in_valid = 1'b1; vect_in = v_plain; in_tag = 4'd1;
        tick(); exp_cnt++;
        check("bp_ready_after1", 128'(in_ready), 128'(1'b1));
        in_tag = 4'd2;
        tick(); exp_cnt++;
        check("bp_ready_full", 128'(in_ready), 128'(1'b0));
        in_tag = 4'd3; vect_in = v_fwd;
        tick();
        check("bp_held_off", 128'(blk_count), 128'(exp_cnt));
        check("bp_ready_still0", 128'(in_ready), 128'(1'b0));
        check("bp_head_tag1", 128'(out_tag), 128'h1);
        out_ready = 1'b1;
        tick();
        check("bp_head_tag2", 128'(out_tag), 128'h2);
        check("bp_ready_again", 128'(in_ready), 128'(1'b1));
        tick(); exp_cnt++;
        in_valid = 1'b0;
        check("bp_head_tag3", 128'(out_tag), 128'h3);
        check("bp_tag3_data", 128'(vect_out), 128'(v_fwd2));
        check("bp_blk_count", 128'(blk_count), 128'(exp_cnt));
        tick();
        check("bp_drained", 128'(out_valid), 128'(1'b0));

        // Full throughput: one block per cycle with no bubbles
        in_valid = 1'b1; vect_in = v_plain;
        for (int i = 0; i < 8; i++) begin
            in_tag = 4'(i + 8);
            tick(); exp_cnt++;
            check($sformatf("tp_valid_%0d", i), 128'(out_valid), 128'(1'b1));
            check($sformatf("tp_tag_%0d", i),   128'(out_tag),   128'(i + 8));
        end
        in_valid = 1'b0;
        tick();
        check("tp_drained",   128'(out_valid), 128'(1'b0));
        check("tp_blk_count", 128'(blk_count), 128'(exp_cnt));

        // Clear with two buffered entries; same-cycle beat is discarded
        out_ready = 1'b0; in_valid = 1'b1;
        tick(); tick(); exp_cnt += 2;
        check("clr_pre_ready", 128'(in_ready), 128'(1'b0));
        clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", 128'(out_valid), 128'(1'b0));
        check("clr_in_ready",  128'(in_ready),  128'(1'b1));
        check("clr_vect_out",  128'(vect_out),  128'h0);
        check("clr_blk_count", 128'(blk_count), 128'(exp_cnt));

        // Reset mid-stream drops entries and zeroes the counter
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check("rst2_pre_valid", 128'(out_valid), 128'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst2_in_ready",  128'(in_ready),  128'(1'b1));
        check("rst2_vect_out",  128'(vect_out),  128'h0);
        check("rst2_blk_count", 128'(blk_count), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Streaming, parametrised AES ShiftRows / InvShiftRows unit with valid/ready handshake on both sides.
- Sits between the vector register file and the SubBytes/MixColumns lanes of the SIMD datapath.
- Generalises column count and word width, adds per-beat inverse mode and a tag passthrough.
- Uses a 2-entry elastic output buffer; sustains one block per cycle.

Parameters:
- regSize, 32, width of one column word in bits; must be a multiple of 8; rows = regSize/8.
- vecSize, 4, number of column words per block.
- TAG_W, 4, width of the sideband tag carried with each block.
- CNT_W, 16, width of the accepted-block counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of the buffer; the counter is kept.
- in_valid  in  1  an input block is presented.
- in_ready  out  1  the unit can accept a block this cycle.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled per beat.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- vect_in  in  [vecSize-1:0][regSize-1:0]  input columns; byte 0 is the MSB byte of each word.
- out_valid  out  1  the head block is valid.
- out_ready  in  1  the consumer accepts the head block.
- out_tag  out  TAG_W  tag of the head block.
- vect_out  out  [vecSize-1:0][regSize-1:0]  transformed columns of the head block.
- blk_count  out  CNT_W  number of accepted input beats.

Behaviour:
- Transform, for column c and row r (byte r of a word):
  - forward: out[c].byte[r] = in[(c+r) mod vecSize].byte[r]
  - inverse: out[c].byte[r] = in[(c-r) mod vecSize].byte[r]
  - Index arithmetic is modulo vecSize; rows beyond vecSize wrap.
- The transform is applied combinationally at the input. The result is written into a 2-entry FIFO along with in_tag.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < 2). It depends on state only, never on out_ready.
- out_valid = (count > 0). vect_out and out_tag always show the head entry.
- Latency: a block accepted in cycle N is visible with out_valid at cycle N+1.
- Throughput: one block per cycle while out_ready is held high.
- count transitions:
  - accept only: +1
  - pop only: -1
  - accept and pop together: count unchanged, write pointer and read pointer both advance.
  - count 2 with pop: no accept that cycle, because in_ready=0.
- Pointers are 1 bit each and wrap 1->0.
- Held data: while out_valid && !out_ready, vect_out and out_tag stay stable.
- Changes to the input while in_ready=0 are ignored.
- blk_count increments on every accept and wraps from all-ones to 0.
- clear: count and pointers go to 0 next cycle; any accept in the same cycle is discarded and not counted. blk_count is retained.
- rst:
  - count=0, pointers=0, out_valid=0, in_ready=1, blk_count=0, vect_out=0, out_tag=0.
  - Reset asserted mid-stream drops all buffered blocks.
- rst has priority over clear.
- FIFO storage is not reset. The vect_out=0 reset value comes from muxing the output to 0 when count=0.

Optional Feature:
- SHIFT_ROWS_INV_EN defined: in_inv selects the inverse permutation per beat.
- Undefined: in_inv is ignored and only the forward permutation is synthesised, saving one mux level per byte.

Decomposition:
- Package shift_rows_pkg holds:
  - BYTE_W=8
  - function rows_of(regSize)
  - typedef vec_t (packed array of vecSize x regSize)
  - typedef entry_t {vec_t data; logic [TAG_W-1:0] tag}
- Sub-module shift_rows_perm: combinational permutation with parameters regSize and vecSize, ports vect_in, inv and vect_out, instantiated once at the input.

Test Plan:
- Forward ShiftRows:
  - Stimulus: in_inv=0, vect_in = {7b5b5465, 73745665, 63746f72, 5d53475d}, tag=3.
  - Required next cycle: out_valid=1, vect_out = {7b746f5d, 73744765, 63535465, 5d5b5672}, out_tag=3, blk_count=1.
- InvShiftRows:
  - Stimulus: in_inv=1 (macro defined), vect_in = {7b746f5d, 73744765, 63535465, 5d5b5672}.
  - Required: vect_out = {7b5b5465, 73745665, 63746f72, 5d53475d}.
- Backpressure:
  - Stimulus: out_ready=0, 3 back-to-back beats with tags 1, 2, 3.
  - Required: in_ready drops after 2 accepts, beat 3 is held off, blk_count=2.
  - Then out_ready=1: tags pop in order 1, 2; beat 3 is accepted once in_ready=1 again.
- Full throughput:
  - Stimulus: out_ready=1, 8 consecutive beats.
  - Required: 8 outputs on 8 consecutive cycles starting 1 cycle after the first accept, no bubbles, blk_count=8.
- Generalisation:
  - Stimulus: vecSize=2, regSize=32, forward mode, vect_in = {00112233, 44556677}.
  - Required: vect_out = {00552277, 44116633}.
- Reset and clear:
  - Stimulus: rst (or clear) asserted with 2 entries buffered.
  - Required next cycle: out_valid=0, in_ready=1, vect_out=0.
  - blk_count is 0 after rst and retained after clear.
